// File: rtl/spawn_pkg.sv
// spawn_pkg: shared types and constants for the lane spawn scheduler.
//   spawn_state_t : scheduler FSM states
//   spawn_kind_t  : obstacle type field carried on a spawn event
//   KIND_LSB      : lsb of the kind field inside the random word
//   DIR_BIT       : bit of the random word used as spawn direction
package spawn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    EMIT   = 2'd2,
    RELOAD = 2'd3
  } spawn_state_t;

  typedef logic [1:0] spawn_kind_t;

  localparam int KIND_LSB = 0;
  localparam int DIR_BIT  = 2;

endpackage

// File: rtl/lane_gap_bank.sv
// lane_gap_bank: per-lane frame gap down-counters.
//   clk, rst_n : clock, async active-low reset (lane i resets to i)
//   idx        : lane addressed by dec/load and reported on zero
//   dec        : decrement the indexed lane (never wraps below 0)
//   load       : load load_val into the indexed lane (wins over dec)
//   load_val   : reload value
//   zero       : indexed lane counter is 0
module lane_gap_bank
  import spawn_pkg::*;
#(
  parameter int LANES = 8,
  parameter int GAP_W = 8,
  parameter int IW    = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IW-1:0]    idx,
  input  logic             dec,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  output logic             zero
);

  logic [GAP_W-1:0] cnt [LANES];

  // Reset value i staggers the lanes so lane i first spawns on frame i+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) cnt[i] <= GAP_W'(i);
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (idx == IW'(i)) begin
          if (load)
            cnt[i] <= load_val;
          else if (dec && cnt[i] != '0)
            cnt[i] <= cnt[i] - GAP_W'(1);
        end
      end
    end
  end

  assign zero = (cnt[idx] == '0);

endmodule

// File: rtl/lane_spawn_sched.sv
// lane_spawn_sched: once per frame, walks all lanes and emits a spawn event
// for every lane whose gap counter has reached zero.
//   clk, rst_n    : clock, async active-low reset
//   frame, run    : frame pulse, game active (frames ignored when low)
//   rnd, rnd_en   : LFSR word in, advance pulse out (one per consumed value)
//   spawn_valid/ready, spawn_lane/kind/dir : spawn event handshake
//   busy          : scan in progress
//   spawn_count, overrun_count : event / dropped-frame statistics, only
//                   built when SPAWN_STATS_EN is defined, else tied to 0
module lane_spawn_sched
  import spawn_pkg::*;
#(
  parameter int                LANES    = 8,
  parameter int                RAND_W   = 8,
  parameter int                GAP_W    = 8,
  parameter int                MIN_GAP  = 16,
  parameter logic [RAND_W-1:0] GAP_MASK = 8'h3F
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame,
  input  logic                     run,
  input  logic [RAND_W-1:0]        rnd,
  output logic                     rnd_en,
  output logic                     spawn_valid,
  input  logic                     spawn_ready,
  output logic [$clog2(LANES)-1:0] spawn_lane,
  output logic [1:0]               spawn_kind,
  output logic                     spawn_dir,
  output logic                     busy,
  output logic [15:0]              spawn_count,
  output logic [7:0]               overrun_count
);

  localparam int IW = $clog2(LANES);
  // Reload sum is kept one bit wider than either operand so the
  // saturation test sees the true sum.
  localparam int SW = ((RAND_W > GAP_W) ? RAND_W : GAP_W) + 1;
  localparam logic [SW-1:0] GMAX = {{(SW-GAP_W){1'b0}}, {GAP_W{1'b1}}};

  spawn_state_t     state;
  logic [IW-1:0]    idx;
  logic             pending;
  logic             lane_zero;
  logic             last;
  logic [SW-1:0]    sum;
  logic [GAP_W-1:0] reload_val;

  assign last       = (idx == IW'(LANES-1));
  assign sum        = SW'(MIN_GAP) + SW'(rnd & GAP_MASK);
  assign reload_val = (sum > GMAX) ? {GAP_W{1'b1}} : sum[GAP_W-1:0];

  lane_gap_bank #(.LANES(LANES), .GAP_W(GAP_W), .IW(IW)) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .idx      (idx),
    .dec      (state == SCAN && !lane_zero),
    .load     (state == RELOAD),
    .load_val (reload_val),
    .zero     (lane_zero)
  );

  // Outputs decode straight from the state register; rnd_en fires in the
  // capture cycle so rnd has advanced by the time RELOAD samples it.
  assign spawn_valid = (state == EMIT);
  assign busy        = (state != IDLE);
  assign rnd_en      = (state == SCAN && lane_zero) || (state == RELOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      pending    <= 1'b0;
      spawn_lane <= '0;
      spawn_kind <= '0;
      spawn_dir  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!run)
            pending <= 1'b0;
          else if (frame || pending) begin
            idx     <= '0;
            pending <= 1'b0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (!lane_zero) begin
            if (last) state <= IDLE;
            else      idx   <= idx + IW'(1);
          end else begin
            spawn_lane <= idx;
            spawn_kind <= spawn_kind_t'(rnd[KIND_LSB +: 2]);
            spawn_dir  <= rnd[DIR_BIT];
            state      <= EMIT;
          end
        end
        EMIT: begin
          if (spawn_ready) state <= RELOAD;
        end
        RELOAD: begin
          if (last) state <= IDLE;
          else begin
            idx   <= idx + IW'(1);
            state <= SCAN;
          end
        end
        default: state <= IDLE;
      endcase
      // One-deep frame queue while a scan is in flight; a frame landing on
      // the final scan cycle restarts the scan right after IDLE.
      if (state != IDLE && frame) pending <= 1'b1;
    end
  end

`ifdef SPAWN_STATS_EN
  logic frame_drop;
  assign frame_drop = frame && (state != IDLE) && pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spawn_count   <= '0;
      overrun_count <= '0;
    end else begin
      if (spawn_valid && spawn_ready) spawn_count <= spawn_count + 16'd1;
      if (frame_drop && overrun_count != 8'hFF)
        overrun_count <= overrun_count + 8'd1;
    end
  end
`else
  assign spawn_count   = '0;
  assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_lane_spawn_sched.sv
// tb_lane_spawn_sched: directed + randomized bench for lane_spawn_sched.
// A lane-level model predicts each frame's spawn events and the random
// values they consume; a negedge monitor checks handshake rules and pops
// the expected events as they are accepted.
module tb_lane_spawn_sched;

  localparam int        LANES    = 8;
  localparam int        RAND_W   = 8;
  localparam int        GAP_W    = 8;
  localparam int        MIN_GAP  = 16;
  localparam logic [7:0] GAP_MASK = 8'hFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  rnd;
  logic        rnd_en;
  logic        spawn_valid;
  logic        spawn_ready = 1'b0;
  logic [2:0]  spawn_lane;
  logic [1:0]  spawn_kind;
  logic        spawn_dir;
  logic        busy;
  logic [15:0] spawn_count;
  logic [7:0]  overrun_count;

  lane_spawn_sched #(
    .LANES(LANES), .RAND_W(RAND_W), .GAP_W(GAP_W),
    .MIN_GAP(MIN_GAP), .GAP_MASK(GAP_MASK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame(frame), .run(run), .rnd(rnd),
    .rnd_en(rnd_en), .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_lane(spawn_lane), .spawn_kind(spawn_kind), .spawn_dir(spawn_dir),
    .busy(busy), .spawn_count(spawn_count), .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Random source: fixed value for directed tests, else a pre-drawn pool
  // advanced by one entry per rnd_en pulse.
  logic [7:0] rv [4096];
  int         p = 0;
  bit         fixed_mode = 1'b1;
  logic [7:0] fixed_val = 8'h00;
  logic [11:0] pidx;
  assign pidx = p[11:0];
  assign rnd  = fixed_mode ? fixed_val : rv[pidx];
  always @(posedge clk) if (rnd_en) p <= p + 1;

  // Lane-level model
  typedef struct { int lane; int kind; int dir; } ev_t;
  ev_t expq[$];
  int  mcnt [LANES];
  int  mp;

  function automatic int rval(input int k);
    logic [11:0] kk;
    kk = k[11:0];
    return fixed_mode ? int'(fixed_val) : int'(rv[kk]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) mcnt[i] = i;
    expq.delete();
    mp = p;
  endtask

  task automatic model_scan();
    ev_t e;
    int  r, g;
    for (int i = 0; i < LANES; i++) begin
      if (mcnt[i] == 0) begin
        r = rval(mp);
        e.lane = i; e.kind = r % 4; e.dir = (r / 4) % 2;
        expq.push_back(e);
        g = MIN_GAP + (rval(mp + 1) & int'(GAP_MASK));
        mcnt[i] = (g > 255) ? 255 : g;
        mp += 2;
      end else begin
        mcnt[i] = mcnt[i] - 1;
      end
    end
  endtask

  // Monitor
  int   n_ev = 0, n_rnden = 0, n_busy_rise = 0;
  int   last_lane = -1, last_kind = -1, last_dir = -1;
  int   frame_no = 0, lane0_last = -1;
  bit   prev_v = 0, prev_hs = 0, prev_busy = 0;
  int   pl = 0, pk = 0, pd = 0;

  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) begin
      prev_v = 0; prev_hs = 0; prev_busy = 0;
    end else begin
      if (!busy) chk("rnd_en_idle", int'(rnd_en), 0);
      if (spawn_valid && !spawn_ready) chk("rnd_en_wait", int'(rnd_en), 0);
      if (prev_hs) chk("valid_drop", int'(spawn_valid), 0);
      if (prev_v && !prev_hs) begin
        chk("valid_hold", int'(spawn_valid), 1);
        chk("lane_stable", int'(spawn_lane), pl);
        chk("kind_stable", int'(spawn_kind), pk);
        chk("dir_stable", int'(spawn_dir), pd);
      end
      if (rnd_en) n_rnden++;
      if (busy && !prev_busy) n_busy_rise++;
      if (spawn_valid && spawn_ready) begin
        n_ev++;
        last_lane = int'(spawn_lane);
        last_kind = int'(spawn_kind);
        last_dir  = int'(spawn_dir);
        if (spawn_lane == 3'd0) lane0_last = frame_no;
        if (expq.size() == 0) chk("unexpected_event", 1, 0);
        else begin
          e = expq.pop_front();
          chk("ev_lane", int'(spawn_lane), e.lane);
          chk("ev_kind", int'(spawn_kind), e.kind);
          chk("ev_dir", int'(spawn_dir), e.dir);
        end
      end
      prev_v    = spawn_valid;
      prev_hs   = spawn_valid && spawn_ready;
      prev_busy = busy;
      pl = int'(spawn_lane); pk = int'(spawn_kind); pd = int'(spawn_dir);
    end
  end

  bit rdy_rand = 0;
  int last_cyc = 0;
  int ev_base = 0;

  task automatic step();
    @(posedge clk); #1;
    if (rdy_rand) spawn_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; frame = 1'b0;
    step(); step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(spawn_valid), 0);
    chk("rst_rnd_en", int'(rnd_en), 0);
    chk("rst_lane", int'(spawn_lane), 0);
    chk("rst_spawn_count", int'(spawn_count), 0);
    chk("rst_overrun", int'(overrun_count), 0);
    model_reset();
    frame_no = 0;
    ev_base = n_ev;
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 1;
    while (busy && cyc < 4000) begin
      step();
      if (busy) cyc++;
    end
    if (busy) chk(name, 0, 1);
    last_cyc = cyc;
  endtask

  task automatic do_frame(input bit scan);
    frame_no++;
    if (scan) model_scan();
    frame = 1'b1; step(); frame = 1'b0;
    if (scan) begin
      chk("busy_start", int'(busy), 1);
      wait_idle("scan_timeout");
      chk("rnd_consumed", p, mp);
      chk("events_left", expq.size(), 0);
    end else begin
      chk("busy_norun", int'(busy), 0);
    end
    step();
  endtask

  task automatic check_stats();
`ifdef SPAWN_STATS_EN
    chk("spawn_count", int'(spawn_count), (n_ev - ev_base) % 65536);
`else
    chk("spawn_count", int'(spawn_count), 0);
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, r0, b0, cyc;
    for (int i = 0; i < 4096; i++) rv[i] = 8'($urandom);

    // 1: single spawn, rnd=05
    fixed_mode = 1; fixed_val = 8'h05; run = 1; spawn_ready = 1;
    do_reset();
    e0 = n_ev; r0 = n_rnden; lane0_last = -1;
    do_frame(1);
    chk("t1_events", n_ev - e0, 1);
    chk("t1_lane", last_lane, 0);
    chk("t1_kind", last_kind, 1);
    chk("t1_dir", last_dir, 1);
    chk("t1_rnden", n_rnden - r0, 2);
    chk("t1_busy_cycles", last_cyc, LANES + 2);
    for (int f = 2; f <= 23; f++) do_frame(1);
    chk("t1_lane0_respawn", lane0_last, 23);
    check_stats();

    // 2: staggered first spawns, rnd=00, reload 16
    fixed_val = 8'h00;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      e0 = n_ev;
      do_frame(1);
      chk("t2_events", n_ev - e0, 1);
      chk("t2_lane", last_lane, k);
    end
    e0 = n_ev; lane0_last = -1;
    for (int f = 5; f <= 18; f++) do_frame(1);
    chk("t2_events_5_18", n_ev - e0, 5);
    chk("t2_lane0_respawn", lane0_last, 18);

    // 3: stall in EMIT
    fixed_val = 8'h05; spawn_ready = 0;
    do_reset();
    model_scan();
    frame = 1; step(); frame = 0;
    cyc = 0;
    while (!spawn_valid && cyc < 20) begin step(); cyc++; end
    chk("t3_valid", int'(spawn_valid), 1);
    r0 = n_rnden;
    repeat (10) step();
    chk("t3_rnden_wait", n_rnden - r0, 0);
    chk("t3_valid_held", int'(spawn_valid), 1);
    chk("t3_lane", int'(spawn_lane), 0);
    chk("t3_kind", int'(spawn_kind), 1);
    chk("t3_dir", int'(spawn_dir), 1);
    spawn_ready = 1;
    step();
    chk("t3_reload_rnd_en", int'(rnd_en), 1);
    chk("t3_reload_valid", int'(spawn_valid), 0);
    wait_idle("t3_timeout");
    chk("t3_rnd_consumed", p, mp);
    chk("t3_events_left", expq.size(), 0);

    // 4: frames while stalled -> one restart, one overrun
    spawn_ready = 0;
    do_reset();
    model_scan(); model_scan();
    b0 = n_busy_rise;
    frame = 1; step(); frame = 0; step();
    frame = 1; step(); frame = 0; step();
    frame = 1; step(); frame = 0; step();
    spawn_ready = 1;
    repeat (60) step();
    chk("t4_scans", n_busy_rise - b0, 2);
    chk("t4_idle", int'(busy), 0);
    chk("t4_rnd_consumed", p, mp);
    chk("t4_events_left", expq.size(), 0);
`ifdef SPAWN_STATS_EN
    chk("t4_overrun", int'(overrun_count), 1);
`else
    chk("t4_overrun", int'(overrun_count), 0);
`endif
    check_stats();

    // 5: reload saturation 16+255 -> 255
    fixed_val = 8'hFF;
    do_reset();
    lane0_last = -1;
    do_frame(1);
    chk("t5_lane", last_lane, 0);
    chk("t5_kind", last_kind, 3);
    chk("t5_dir", last_dir, 1);
    for (int f = 2; f <= 256; f++) do_frame(1);
    chk("t5_lane0_before", lane0_last, 1);
    do_frame(1);
    chk("t5_lane0_respawn", lane0_last, 257);

    // 6: async reset while in EMIT
    fixed_val = 8'h05; spawn_ready = 0;
    do_reset();
    model_scan();
    frame = 1; step(); frame = 0;
    cyc = 0;
    while (!spawn_valid && cyc < 20) begin step(); cyc++; end
    chk("t6_in_emit", int'(spawn_valid), 1);
    #2 rst_n = 0;
    #1;
    chk("t6_valid_async", int'(spawn_valid), 0);
    chk("t6_busy_async", int'(busy), 0);
    step();
    model_reset();
    frame_no = 0; ev_base = n_ev;
    rst_n = 1; spawn_ready = 1;
    step();
    e0 = n_ev;
    do_frame(1);
    chk("t6_events", n_ev - e0, 1);
    chk("t6_lane", last_lane, 0);
    do_frame(1);
    chk("t6_lane_next", last_lane, 1);

    // Randomized: pool values, random ready, occasional run=0 frames
    fixed_mode = 0; rdy_rand = 1; run = 1;
    do_reset();
    for (int f = 0; f < 120; f++) begin
      if ($urandom_range(0, 7) == 0) begin
        run = 0; do_frame(0); run = 1;
      end else begin
        do_frame(1);
      end
    end
    check_stats();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_spawn_sched.md
Name: lane_spawn_sched

Overview:
- Consumes the pseudo-random word from the game's LFSR and decides, once per video frame, which lanes spawn a new obstacle.
- Drives the LFSR enable so that every random value is consumed exactly once.
- Each lane has a per-lane gap down-counter. Spawn events go to the sprite/obstacle manager over a valid/ready handshake.

Parameters:
- LANES, 8, number of obstacle lanes (≥2)
- RAND_W, 8, width of random input (≥3)
- GAP_W, 8, width of per-lane gap counters
- MIN_GAP, 16, minimum frames between spawns in one lane
- GAP_MASK, 8'h3F, mask applied to random word for the gap increment (RAND_W bits)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- frame  in  1  one-cycle pulse per video frame
- run  in  1  game active; frames are ignored when low
- rnd  in  RAND_W  current LFSR output
- rnd_en  out  1  advance LFSR (one-cycle pulse per consumed value)
- spawn_valid  out  1  spawn event valid
- spawn_ready  in  1  consumer accepts event
- spawn_lane  out  $clog2(LANES)  lane index of event
- spawn_kind  out  2  obstacle type, rnd[1:0] at capture
- spawn_dir  out  1  direction, rnd[2] at capture
- busy  out  1  scan in progress (state != IDLE)
- spawn_count  out  16  see Optional Feature
- overrun_count  out  8  see Optional Feature

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; pending=0.
  - cnt[i]=i, truncated to GAP_W. Lanes are staggered: lane i first spawns on frame i+1.
- States: IDLE, SCAN, EMIT, RELOAD.
- IDLE:
  - On (frame|pending) && run: idx=0, pending cleared, go to SCAN.
  - When run=0, frames are dropped and pending is cleared.
- SCAN, one lane per cycle:
  - cnt[idx]!=0: decrement it. If idx==LANES-1 go to IDLE, else idx++.
  - cnt[idx]==0: capture spawn_lane=idx, spawn_kind=rnd[1:0], spawn_dir=rnd[2]. Pulse rnd_en the same cycle. Go to EMIT.
- EMIT:
  - spawn_valid=1. lane/kind/dir are held stable until spawn_valid&&spawn_ready.
  - On handshake go to RELOAD. Valid deasserts the next cycle. No combinational ready→valid path.
- RELOAD (single cycle):
  - Sample the already-advanced rnd. Compute cnt[idx] = MIN_GAP + (rnd & GAP_MASK) in GAP_W+1 bits, saturated to 2^GAP_W-1. Pulse rnd_en.
  - Then idx++ and return to SCAN, or go to IDLE if idx==LANES-1.
- Random values: each emission consumes exactly two distinct values (capture, reload) and produces exactly two rnd_en pulses. rnd_en is never asserted in IDLE.
- Frame during busy: sets pending (one-deep). A frame while pending is already set is dropped and counted as an overrun.
- Simultaneous frame and scan completion: return to IDLE, then restart on the next cycle via pending.
- run falling mid-scan: the current scan completes, including any outstanding handshake. No abort.
- A lane whose counter is 0 is never decremented (no wrap). MIN_GAP=0 with a masked value of 0 means a spawn on the very next frame.
- Latency: frame → first SCAN cycle is 1 cycle. A scan with no spawns takes LANES cycles. Each emission adds 2 cycles plus the ready wait.

Optional Feature:
- Macro SPAWN_STATS_EN.
- Defined:
  - spawn_count increments on every handshake and wraps at 16 bits.
  - overrun_count increments on every dropped frame and saturates at 255.
  - Both reset to 0.
- Undefined: both ports are tied to 0; no counter logic is synthesised.

Decomposition:
- Package spawn_pkg:
  - state enum spawn_state_t {IDLE, SCAN, EMIT, RELOAD}.
  - typedef spawn_kind_t (2 bits).
  - Constants KIND_LSB=0, DIR_BIT=2.
- Sub-module lane_gap_bank:
  - LANES×GAP_W counter array.
  - Ports: index, decrement, load, load value, and zero flag for the indexed lane.
  - The top level keeps the FSM, handshake and random sampling.

Test Plan:
1. Reset, run=1, rnd held 8'h05, ready=1, one frame → exactly one event: lane 0, kind 01, dir 1. Two rnd_en pulses. cnt[0]=21. busy low after LANES+2 cycles.
2. Consecutive frames 1..4, rnd=8'h00, ready=1 → lane k spawns on frame k+1 (k=0..3). No other events. Reloaded counters = 16.
3. Event pending, ready held 0 for 10 cycles → valid, lane, kind and dir stable throughout. No rnd_en during the wait. Ready=1 → RELOAD next cycle.
4. Frame pulses at cycles 0, 2 and 4 while the scan is stalled → one pending restart. overrun_count=1 (with SPAWN_STATS_EN).
5. rnd=8'hFF, GAP_MASK=8'hFF, MIN_GAP=16 → reload saturates to 255.
6. rst_n asserted while in EMIT → spawn_valid=0 immediately (async). After release, state=IDLE and cnt[i]=i.
